ransac_memoria_dados_pipe: RTL and testbench
============================================

RANSAC_MEMORIA_DADOS_PIPE -- requirements
Module: ransac_memoria_dados_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 14, word address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted read to readdatavalid.
REQ-004 The block SHALL have parameter WRITE_MODE, default 1: 0 = any write accepted, 1 = write accepted only when debugaccess=1.
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill sequence runs after reset release.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, all logic rising-edge; reset_n  in  1  asynchronous active-low reset.
REQ-007 address  in  ADDR_W  word address.
REQ-008 byteenable  in  DATA_W/8  per-byte write enable.
REQ-009 chipselect  in  1  slave select; read/write ignored when 0.
REQ-010 read  in  1  read request.
REQ-011 write  in  1  write request.
REQ-012 writedata  in  DATA_W  write data.
REQ-013 debugaccess  in  1  write qualifier for WRITE_MODE=1.
REQ-014 clear  in  1  single-cycle pulse starting a zero-fill.
REQ-015 waitrequest  out  1  high = request not accepted this cycle.
REQ-016 readdata  out  DATA_W  read data, valid with readdatavalid.
REQ-017 readdatavalid  out  1  one-cycle read-return strobe.
REQ-018 busy  out  1  zero-fill in progress.
REQ-019 err  out  1  sticky protocol-error flag.
REQ-020 err_clr  in  1  synchronous clear of err.

Function
REQ-021 The block SHALL use FSM states CLEAR and RUN; storage is DEPTH x DATA_W inferred RAM, contents not affected by reset_n.
REQ-022 CLEAR SHALL write zero to address 0..DEPTH-1, one word per cycle, ascending; after writing DEPTH-1 the FSM SHALL enter RUN the next cycle (CLEAR lasts exactly DEPTH cycles).
REQ-023 waitrequest and busy SHALL be 1 in CLEAR and 0 in RUN; no host request SHALL be accepted in CLEAR.
REQ-024 clear=1 in RUN SHALL enter CLEAR with counter 0 the next cycle; any request in that same cycle SHALL still be accepted; clear during CLEAR SHALL be ignored.
REQ-025 A write SHALL be accepted when RUN, chipselect=1, write=1, read=0 and (WRITE_MODE=0 or debugaccess=1); only bytes with byteenable=1 SHALL update.
REQ-026 A write qualifying except debugaccess=0 (WRITE_MODE=1) SHALL be dropped and set err.
REQ-027 A read SHALL be accepted when RUN, chipselect=1, read=1, write=0; readdata SHALL carry the word and readdatavalid pulse exactly READ_LATENCY cycles later.
REQ-028 Reads SHALL be fully pipelined: one read per cycle accepted, returns in order, no bubbles.
REQ-029 A read to an address written in the previous cycle SHALL return the new data (write-then-read coherency, byte-merged).
REQ-030 chipselect=1 with read=1 and write=1 SHALL perform neither operation and set err.
REQ-031 err SHALL stay 1 until err_clr=1; err_clr and a new error in the same cycle SHALL leave err=1.
REQ-032 Reads in flight when clear is pulsed SHALL complete with pre-clear data.
REQ-033 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-034 While reset_n=0: readdatavalid=0, readdata=0, err=0, pipeline flushed, clear counter=0.
REQ-035 While reset_n=0: FSM=CLEAR (waitrequest=busy=1) if CLEAR_ON_RESET=1, else RUN (waitrequest=busy=0).
REQ-036 reset_n asserted mid-CLEAR or mid-read SHALL abort; CLEAR restarts from address 0 after release; aborted reads never return.

Verification
REQ-037 Defaults, release reset -> busy=waitrequest=1 for exactly 16384 cycles; any read then returns 0x00000000.
REQ-038 Write 0xDEADBEEF at addr 5, debugaccess=1, byteenable=4'b0101; read addr 5 -> 0x00AD00EF after READ_LATENCY, err=0.
REQ-039 Write addr 7 debugaccess=0 (WRITE_MODE=1) -> err=1, addr 7 unchanged; err_clr -> err=0.
REQ-040 READ_LATENCY=2, back-to-back reads addr 0..3 holding known data -> four consecutive readdatavalid pulses, in order, first 2 cycles after first request.
REQ-041 Write 0x12345678 addr 9 then read addr 9 next cycle -> 0x12345678.
REQ-042 Pulse clear, reset_n low at counter 100 -> after release, CLEAR restarts at 0 and lasts full DEPTH cycles.

Source files
------------

// File: rtl/ransac_memoria_dados_pipe.sv
// ransac_memoria_dados_pipe: Avalon-MM word RAM with zero-fill sequencer, byte-enable writes and pipelined reads.
module ransac_memoria_dados_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                debugaccess,
  input  logic                clear,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              run, req_ok, rd_acc, wr_acc, wr_bad;
  assign run         = state == RUN;
  assign req_ok      = run & chipselect & (read ^ write);
  assign rd_acc      = req_ok & read;
  assign wr_acc      = req_ok & write & ((WRITE_MODE == 0) | debugaccess);
  assign wr_bad      = run & chipselect & ((read & write) | (write & ~read & (WRITE_MODE != 0) & ~debugaccess));
  assign waitrequest = ~run;
  assign busy        = ~run;
  // Zero-fill and host writes share the single write port; CLEAR never overlaps accepted host writes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (!run || (wr_acc && byteenable[b]))
        mem[run ? address : cnt][8*b +: 8] <= run ? writedata[8*b +: 8] : 8'h00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt           <= '0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (&cnt) state <= RUN;
      end else if (clear) begin
        state <= CLEAR;
        cnt   <= '0;
      end
      err      <= (err & ~err_clr) | wr_bad;
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= mem[address];
      if (READ_LATENCY == 1) begin
        readdatavalid <= rd_acc;
        if (rd_acc) readdata <= mem[address];
      end else begin
        readdatavalid <= s1_valid;
        if (s1_valid) readdata <= s1_data;
      end
    end
  end
endmodule

// File: tb/tb_ransac_memoria_dados_pipe.sv
// tb_ransac_memoria_dados_pipe: directed checks of zero-fill, byte writes, errors, coherency and read pipelining.
module tb_ransac_memoria_dados_pipe;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write, debugaccess, clear, err_clr;
  logic [31:0] writedata;
  logic        waitrequest, readdatavalid, busy, err;
  logic [31:0] readdata;
  logic        waitrequest2, readdatavalid2, busy2, err2;
  logic [31:0] readdata2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ransac_memoria_dados_pipe dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .clear(clear), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  ransac_memoria_dados_pipe #(.ADDR_W(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address[3:0]), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .debugaccess(debugaccess), .clear(clear), .waitrequest(waitrequest2),
    .readdata(readdata2), .readdatavalid(readdatavalid2), .busy(busy2), .err(err2),
    .err_clr(err_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    chipselect = 0; read = 0; write = 0; clear = 0; err_clr = 0; debugaccess = 0;
  endtask

  task automatic test_reset;
    int n;
    reset_n = 0; idle(); address = '0; byteenable = '0; writedata = '0;
    repeat (3) tick();
    checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", readdatavalid); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b1 || waitrequest !== 1'b1) begin errors++; $display("FAIL reset_busy got %b/%b want 1/1", busy, waitrequest); end
    reset_n = 1; n = 0;
    while (busy === 1'b1 && n < 20000) begin tick(); n++; end
    checks++; if (n != 16384) begin errors++; $display("FAIL clear_len got %0d want 16384", n); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL run_waitreq got %b want 0", waitrequest); end
    address = 100; chipselect = 1; read = 1; tick(); idle();
    checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin errors++; $display("FAIL read_zero got %b/%h want 1/00000000", readdatavalid, readdata); end
  endtask

  task automatic test_byte_write;
    address = 5; writedata = 32'hDEADBEEF; byteenable = 4'b0101; debugaccess = 1; chipselect = 1; write = 1;
    tick(); write = 0; read = 1;
    tick(); idle();
    checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h00AD00EF) begin errors++; $display("FAIL byte_write got %b/%h want 1/00ad00ef", readdatavalid, readdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL byte_write_err got %b want 0", err); end
  endtask

  task automatic test_coherency;
    address = 9; writedata = 32'h12345678; byteenable = 4'hF; debugaccess = 1; chipselect = 1; write = 1;
    tick(); write = 0; read = 1;
    tick(); idle();
    checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h12345678) begin errors++; $display("FAIL coherency got %b/%h want 1/12345678", readdatavalid, readdata); end
    tick();
    checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h12345678) begin errors++; $display("FAIL hold got %b/%h want 0/12345678", readdatavalid, readdata); end
  endtask

  task automatic test_err;
    address = 7; writedata = 32'hFFFFFFFF; byteenable = 4'hF; debugaccess = 0; chipselect = 1; write = 1;
    tick(); write = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL wr_noauth_err got %b want 1", err); end
    read = 1; tick(); read = 0;
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL wr_dropped got %h want 00000000", readdata); end
    err_clr = 1; chipselect = 0; tick(); err_clr = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err); end
    address = 9; writedata = 32'h0; debugaccess = 1; chipselect = 1; read = 1; write = 1;
    tick();
    checks++; if (err !== 1'b1 || readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_wr_err got err %b rdv %b want 1/0", err, readdatavalid); end
    err_clr = 1; tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_clr_collide got %b want 1", err); end
    idle(); err_clr = 1; tick(); err_clr = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b want 0", err); end
    chipselect = 1; read = 1; tick(); idle();
    checks++; if (readdata !== 32'h12345678) begin errors++; $display("FAIL rd_wr_nowrite got %h want 12345678", readdata); end
  endtask

  task automatic test_back_to_back;
    byteenable = 4'hF; debugaccess = 1; chipselect = 1; write = 1;
    for (int i = 0; i < 4; i++) begin address = 14'(i); writedata = 32'h100 + i; tick(); end
    idle();
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin chipselect = 1; read = 1; address = 14'(t); end else idle();
      tick();
      checks++;
      if (readdatavalid2 !== (t >= 1 && t <= 4)) begin errors++; $display("FAIL b2b_rdv2 t=%0d got %b", t, readdatavalid2); end
      else if (t >= 1 && t <= 4 && readdata2 !== 32'h100 + t - 1) begin errors++; $display("FAIL b2b_data2 t=%0d got %h want %h", t, readdata2, 32'h100 + t - 1); end
      checks++;
      if (readdatavalid !== (t < 4)) begin errors++; $display("FAIL b2b_rdv1 t=%0d got %b", t, readdatavalid); end
      else if (t < 4 && readdata !== 32'h100 + t) begin errors++; $display("FAIL b2b_data1 t=%0d got %h want %h", t, readdata, 32'h100 + t); end
    end
  endtask

  task automatic test_clear_reset;
    int n;
    address = 9; chipselect = 1; read = 1; clear = 1; tick(); idle();
    checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h12345678) begin errors++; $display("FAIL clear_inflight got %b/%h want 1/12345678", readdatavalid, readdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_enter got %b want 1", busy); end
    repeat (99) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_mid got %b want 1", busy); end
    reset_n = 0; tick(); tick();
    checks++; if (readdatavalid !== 1'b0 || readdata !== 32'h0 || err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset got rdv %b data %h err %b busy %b", readdatavalid, readdata, err, busy); end
    reset_n = 1; n = 0;
    while (busy === 1'b1 && n < 20000) begin clear = (n == 50); tick(); n++; end
    clear = 0;
    checks++; if (n != 16384) begin errors++; $display("FAIL restart_len got %0d want 16384", n); end
    address = 9; chipselect = 1; read = 1; tick(); idle();
    checks++; if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin errors++; $display("FAIL after_clear got %b/%h want 1/00000000", readdatavalid, readdata); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_coherency();
    test_err();
    test_back_to_back();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
